mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, shared-memory address width in bits.
REQ-002 Parameter DATA_W, default 32, data word width in bits.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low (0 = reset, sampled on rising clk).
REQ-005 reqX (X=0,1)  input  1  core X memory request; level, held until ackX.
REQ-006 weX  input  1  core X write enable (1 = store, 0 = load).
REQ-007 addrX  input  ADDR_W  core X byte address.
REQ-008 wdataX  input  DATA_W  core X store data.
REQ-009 ackX  output  1  one-cycle completion pulse to core X.
REQ-010 rdataX  output  DATA_W  load data to core X, valid only while ackX=1.
REQ-011 mem_en  output  1  shared memory access strobe.
REQ-012 mem_we  output  1  shared memory write enable.
REQ-013 mem_addr  output  ADDR_W  shared memory address.
REQ-014 mem_wdata  output  DATA_W  shared memory write data.
REQ-015 mem_rdata  input  DATA_W  shared memory read data, valid the cycle after mem_en (synchronous read).

Function
REQ-016 FSM states: IDLE, ISSUE, RESP; one transaction in flight at a time.
REQ-017 IDLE: no request -> stay IDLE; any reqX=1 -> grant one core, latch its we/addr/wdata and owner, go ISSUE.
REQ-018 Tie (req0=req1=1 in IDLE): grant the core not equal to last_grant; single request granted regardless of last_grant.
REQ-019 last_grant updates to the granted core on every IDLE->ISSUE transition.
REQ-020 ISSUE: mem_en=1, mem_we/mem_addr/mem_wdata = latched values, exactly one cycle; always -> RESP.
REQ-021 RESP: ack(owner)=1 for exactly one cycle, rdata(owner)=mem_rdata; always -> IDLE.
REQ-022 Latency: req sampled in IDLE at cycle N -> mem_en at N+1 -> ack at N+2; peak throughput one access per 3 cycles.
REQ-023 Outside ISSUE: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-024 Non-owner ack=0 and rdata=0 at all times; owner rdata=0 outside RESP.
REQ-025 Store (we=1): ack still pulses in RESP; rdata content is don't-care to the core but SHALL equal mem_rdata.
REQ-026 No combinational path from any reqX/addrX/weX/wdataX to mem_* outputs; mem_* driven from latched registers.
REQ-027 Changes on reqX/addrX of the owner during ISSUE/RESP are ignored; latched values used.
REQ-028 Requester deasserts req at the clock edge ending its ack cycle; req still high in the following IDLE is a new request.
REQ-029 Non-owner request arriving during ISSUE/RESP is held by the requester and arbitrated in the next IDLE.

Reset
REQ-030 While rst=0 at a rising edge: state=IDLE, last_grant=1 (core 0 wins first tie), latched regs=0.
REQ-031 All outputs 0 in the cycle after a reset edge.
REQ-032 Reset during ISSUE or RESP aborts the transaction: no ack issued, mem_en 0 next cycle; still-high req re-arbitrated after rst returns to 1.

Structure
REQ-033 Shared package holds state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2) and default ADDR_W/DATA_W constants.
REQ-034 Single flat module; no sub-module; instantiated once in multicore_processor between core0/core1 memory stages and the shared data memory.

Verification
REQ-035 Core0 load addr=0x10, memory returns 0x0000000F -> mem_en at N+1 with mem_addr=0x10, ack0=1 and rdata0=15 at N+2, ack1=0 throughout.
REQ-036 Core1 store addr=0x20 wdata=27, then load 0x20 -> mem_we=1/mem_wdata=27 in first ISSUE; second ack1 returns rdata1=27.
REQ-037 req0=req1=1 from reset, held -> grants in order 0,1,0,1; acks at cycles N+2, N+5, N+8, N+11.
REQ-038 req1 rises while core0 in ISSUE -> core0 completes undisturbed; core1 granted at next IDLE, ack1 three cycles later.
REQ-039 rst=0 asserted during ISSUE of core0 -> no ack0, all outputs 0; after release with req0 held, full transaction repeats with correct data.
REQ-040 Owner changes addr0 from 0x10 to 0x30 during ISSUE -> mem_addr stays 0x10.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-core memory arbiter: state encoding and default widths.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-core round-robin arbiter in front of a synchronous-read shared memory.
// One access in flight at a time: IDLE (arbitrate) -> ISSUE (mem strobe) -> RESP (ack).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              gnt;

  // On a tie the core that did not win last time goes; a lone request always wins.
  assign gnt = (req0 & req1) ? ~last_grant_q : req1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          owner_d      = gnt;
          last_grant_d = gnt;
          we_d         = gnt ? we1    : we0;
          addr_d       = gnt ? addr1  : addr0;
          wdata_d      = gnt ? wdata1 : wdata0;
          state_d      = ISSUE;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory side is driven only from latched registers, never from core inputs.
  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = mem_en ? we_q    : 1'b0;
  assign mem_addr  = mem_en ? addr_q  : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;

  assign ack0   = (state_q == RESP) & ~owner_q;
  assign ack1   = (state_q == RESP) &  owner_q;
  assign rdata0 = ack0 ? mem_rdata : '0;
  assign rdata1 = ack1 ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: transaction-level reference schedule plus directed scenarios.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        ack0, ack1, mem_en, mem_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .rdata0(rdata0), .ack1(ack1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_val(input int a);
    return (a == 16) ? 32'h0000_000F : (32'hA500_0000 | 32'(a));
  endfunction

  // Shared memory: synchronous read, read-before-write, unwritten words read init_val.
  bit          wr_v [256];
  logic [31:0] mem_st [256];
  always_ff @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= wr_v[mem_addr[7:0]] ? mem_st[mem_addr[7:0]] : init_val(int'(mem_addr[7:0]));
      if (mem_we) begin
        mem_st[mem_addr[7:0]] <= mem_wdata;
        wr_v[mem_addr[7:0]]   <= 1'b1;
      end
    end
  end

  int errs = 0, checks = 0;
  int e = 0;

  // Reference: a grant at edge g shows mem_en after g, ack after g+1, next arbitration at g+3.
  int          free_e = 0, iss_e = -10;
  bit          own = 0, last = 1, x_we = 0;
  logic [31:0] x_addr = '0, x_wdata = '0, x_rd = '0;
  logic [31:0] ref_mem [256];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", tag, got, exp, e);
    end
  endtask

  task automatic step();
    bit en, ak;
    if (!rst) begin
      last = 1; iss_e = -10; free_e = e + 1;
    end else if (e >= free_e && (req0 || req1)) begin
      own     = (req0 && req1) ? !last : req1;
      last    = own;
      x_we    = own ? we1 : we0;
      x_addr  = own ? addr1 : addr0;
      x_wdata = own ? wdata1 : wdata0;
      x_rd    = ref_mem[x_addr[7:0]];
      if (x_we) ref_mem[x_addr[7:0]] = x_wdata;
      iss_e   = e;
      free_e  = e + 3;
    end
    @(posedge clk); #1;
    en = (e == iss_e);
    ak = (e == iss_e + 1);
    chk("mem_en",    64'(mem_en),    64'(en));
    chk("mem_we",    64'(mem_we),    64'(en && x_we));
    chk("mem_addr",  64'(mem_addr),  en ? 64'(x_addr)  : 64'd0);
    chk("mem_wdata", 64'(mem_wdata), en ? 64'(x_wdata) : 64'd0);
    chk("ack0",      64'(ack0),      64'(ak && !own));
    chk("ack1",      64'(ack1),      64'(ak && own));
    chk("rdata0",    64'(rdata0),    (ak && !own) ? 64'(x_rd) : 64'd0);
    chk("rdata1",    64'(rdata1),    (ak && own)  ? 64'(x_rd) : 64'd0);
    e++;
  endtask

  task automatic wait_ack(input bit c);
    bit hit = 0;
    for (int i = 0; i < 12 && !hit; i++) begin
      step();
      hit = c ? ack1 : ack0;
    end
    if (!hit) chk("ack_timeout", 64'd0, 64'd1);
  endtask

  task automatic new_req(input bit c);
    if (!c) begin
      req0 = 1; we0 = 1'($urandom); addr0 = 32'($urandom_range(0, 15)) * 4; wdata0 = $urandom;
    end else begin
      req1 = 1; we1 = 1'($urandom); addr1 = 32'($urandom_range(0, 15)) * 4; wdata1 = $urandom;
    end
  endtask

  initial begin
    int n, a0e;
    int q_core[$], q_edge[$];
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

    // reset: everything quiet
    rst = 0; step(); step();
    rst = 1; step();

    // core0 load 0x10 -> 15
    req0 = 1; we0 = 0; addr0 = 32'h10;
    step();
    chk("d_ld_en", 64'(mem_en), 64'd1);
    chk("d_ld_addr", 64'(mem_addr), 64'h10);
    step();
    chk("d_ld_ack0", 64'(ack0), 64'd1);
    chk("d_ld_rd0", 64'(rdata0), 64'd15);
    req0 = 0; step();

    // core1 store 27 to 0x20, then load it back
    req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'd27;
    step();
    chk("d_st_we", 64'(mem_we), 64'd1);
    chk("d_st_wd", 64'(mem_wdata), 64'd27);
    step();
    chk("d_st_ack1", 64'(ack1), 64'd1);
    we1 = 0;
    wait_ack(1);
    chk("d_ld1_rd", 64'(rdata1), 64'd27);
    req1 = 0; step();

    // tie from reset, both held: 0,1,0,1 three cycles apart
    rst = 0; step(); rst = 1;
    req0 = 1; we0 = 0; addr0 = 32'h4;
    req1 = 1; we1 = 0; addr1 = 32'h8;
    n = e;
    for (int i = 0; i < 11; i++) begin
      step();
      if (ack0) begin q_core.push_back(0); q_edge.push_back(e - 1); end
      if (ack1) begin q_core.push_back(1); q_edge.push_back(e - 1); end
    end
    chk("d_tie_cnt", 64'(q_core.size()), 64'd4);
    for (int i = 0; i < 4 && i < q_core.size(); i++) begin
      chk("d_tie_core", 64'(q_core[i]), 64'(i % 2));
      chk("d_tie_edge", 64'(q_edge[i] - n), 64'(1 + 3 * i));
    end
    req0 = 0; req1 = 0; step(); step();

    // req1 rises while core0 in ISSUE
    req0 = 1; we0 = 0; addr0 = 32'h8;
    step();
    req1 = 1; we1 = 0; addr1 = 32'hC;
    step();
    chk("d_late_ack0", 64'(ack0), 64'd1);
    a0e = e - 1;
    req0 = 0;
    wait_ack(1);
    chk("d_late_gap", 64'(e - 1 - a0e), 64'd3);
    req1 = 0; step();

    // reset during core0 ISSUE aborts, held req repeats
    req0 = 1; we0 = 0; addr0 = 32'h10;
    step();
    rst = 0; step();
    chk("d_rst_ack0", 64'(ack0), 64'd0);
    chk("d_rst_en", 64'(mem_en), 64'd0);
    rst = 1;
    wait_ack(0);
    chk("d_rst_rd0", 64'(rdata0), 64'd15);
    req0 = 0; step();

    // owner moves addr during ISSUE: latched address kept
    req0 = 1; we0 = 0; addr0 = 32'h10;
    step();
    addr0 = 32'h30; #1;
    chk("d_hold_addr", 64'(mem_addr), 64'h10);
    step();
    chk("d_hold_rd0", 64'(rdata0), 64'd15);
    req0 = 0; step();

    // random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      step();
      for (int c = 0; c < 2; c++) begin
        bit ak, rq;
        ak = c ? ack1 : ack0;
        rq = c ? req1 : req0;
        if (ak) begin
          if ($urandom_range(0, 1) != 0) new_req(1'(c));
          else if (c == 0) req0 = 0;
          else req1 = 0;
        end else if (!rq) begin
          if ($urandom_range(0, 3) == 0) new_req(1'(c));
        end else if (own == 1'(c) && (e - 1 == iss_e)) begin
          if (c == 0) addr0 = 32'($urandom_range(0, 15)) * 4;
          else addr1 = 32'($urandom_range(0, 15)) * 4;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
